ads8681_seq: RTL and testbench
==============================

ADS8681_SEQ -- requirements
Module: ads8681_seq

Interface
REQ-001 Parameter HALF_DIV, default 2, clk_in cycles per SCLK half-period (SCLK = clk_in/(2*HALF_DIV)), legal range 1..255.
REQ-002 Parameter CONV_CYCLES, default 100, clk_in cycles cs_n is held high before RVS is examined (minimum conversion time), legal range 1..65535.
REQ-003 Parameter RVS_TIMEOUT, default 1000, clk_in cycles allowed for synchronised rvs to go high after CONV_CYCLES.
REQ-004 clk_in  input  1  single system clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  single-cycle request for one conversion+readout.
REQ-007 cont  input  1  continuous mode; level, sampled at frame end.
REQ-008 cmd_valid / cmd_ready  input / output  1 / 1  command handshake, transfer when both high on one edge.
REQ-009 cmd_word  input  32  ADC register command shifted on sdi during the next frame.
REQ-010 cs_n  output  1  ADC CONVST/CS; rising edge starts conversion.
REQ-011 sclk  output  1  SPI clock, mode 0, idle low.
REQ-012 sdi  output  1  serial data to ADC, MSB first.
REQ-013 sdo  input  1  serial data from ADC, MSB first.
REQ-014 rvs  input  1  ADC ready/valid status, asynchronous.
REQ-015 dout  output  16  last conversion result.
REQ-016 dout_valid  output  1  one-cycle pulse, dout updated.
REQ-017 busy  output  1  high in any state except IDLE.
REQ-018 rvs_err  output  1  sticky RVS timeout flag, cleared by next accepted start.

Function
REQ-019 States: IDLE, CONV, WAIT_RVS, SHIFT, DONE.
REQ-020 IDLE: cs_n=0, sclk=0, sdi=0; start=1 -> CONV next cycle; start ignored outside IDLE.
REQ-021 CONV: cs_n=1 from first CONV cycle; stays exactly CONV_CYCLES cycles, then WAIT_RVS.
REQ-022 rvs passes a 2-flop synchroniser before use; WAIT_RVS exits to SHIFT on first cycle synchronised rvs=1.
REQ-023 WAIT_RVS exceeding RVS_TIMEOUT cycles: rvs_err=1, go IDLE, no dout_valid, pending command retained.
REQ-024 SHIFT: cs_n=0, exactly 32 SCLK periods; each period HALF_DIV cycles sclk=0 then HALF_DIV cycles sclk=1.
REQ-025 sdi carries tx bit 31 from first SHIFT cycle; next bit presented on each sclk falling edge.
REQ-026 sdo sampled into 32-bit rx shift register on the last clk_in cycle of each sclk-high phase.
REQ-027 tx = latched command if pending, else 32'h0000_0000 (NOP); pending cleared at entry to DONE.
REQ-028 DONE (one cycle): dout <= rx[31:16], dout_valid=1, sclk=0; cont=1 -> CONV (cs_n rises, back-to-back), else IDLE.
REQ-029 Throughput with cont=1: one result per CONV_CYCLES + RVS wait + 64*HALF_DIV + 1 cycles.
REQ-030 cmd_ready=1 whenever no command pending; accepted command held until sent; at most one pending.
REQ-031 cmd_valid with cmd_ready=0 -> no transfer, cmd_word ignored.
REQ-032 start and cmd acceptance in same cycle: command goes in that same frame.
REQ-033 Counters saturate/reload exactly; no wrap-around glitch on sclk or cs_n.

Reset
REQ-034 rst_n=0 on a clk_in edge: state IDLE, cs_n=0, sclk=0, sdi=0, dout=16'h0000, dout_valid=0, busy=0, rvs_err=0, cmd_ready=1, pending cleared, synchroniser cleared.
REQ-035 Reset mid-frame aborts immediately; partial frame discarded, no dout_valid issued.

Verification
REQ-036 HALF_DIV=2, CONV_CYCLES=100, rvs high, ADC model returns 16'hA5C3: start -> cs_n high 100 cycles, 32 sclk pulses of 4 cycles, dout=16'hA5C3, one dout_valid.
REQ-037 cmd_word=32'hD014_0003 accepted in IDLE, then start -> sdi stream equals D0140003 MSB first; next frame sends all zeros.
REQ-038 cont=1 three frames with values 0001, 7FFF, 8000 -> three dout_valid pulses, cs_n rises in the cycle after each DONE.
REQ-039 rvs held low, RVS_TIMEOUT=1000 -> rvs_err=1 after 100+1000 cycles, state IDLE, no dout_valid; next start clears rvs_err.
REQ-040 rst_n low at SHIFT bit 10 -> next cycle cs_n=0, sclk=0, busy=0, dout unchanged from reset value, no dout_valid.
REQ-041 Second cmd_valid while pending -> cmd_ready=0, first command transmitted, second not accepted.

Source files
------------

// File: rtl/ads8681_seq_if.sv
// Signal bundle between the ADS8681 sequencer and its user/ADC side.
// The slave modport is the sequencer's view, and the master modport is the surrounding system's view.
interface ads8681_seq_if;
   logic        start;
   logic        cont;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_word;
   logic        cs_n;
   logic        sclk;
   logic        sdi;
   logic        sdo;
   logic        rvs;
   logic [15:0] dout;
   logic        dout_valid;
   logic        busy;
   logic        rvs_err;

   modport slave (
      input  start, cont, cmd_valid, cmd_word, sdo, rvs,
      output cmd_ready, cs_n, sclk, sdi, dout, dout_valid, busy, rvs_err
   );

   modport master (
      output start, cont, cmd_valid, cmd_word, sdo, rvs,
      input  cmd_ready, cs_n, sclk, sdi, dout, dout_valid, busy, rvs_err
   );
endinterface

// File: rtl/ads8681_seq.sv
// ADS8681 conversion/readout sequencer.
// Each frame runs: cs_n high for the conversion, a wait for RVS, then one 32-bit SPI mode-0 frame.
module ads8681_seq #(
   parameter int HALF_DIV    = 2,
   parameter int CONV_CYCLES = 100,
   parameter int RVS_TIMEOUT = 1000
) (
   input logic          clk_in,
   input logic          rst_n,
   ads8681_seq_if.slave bus
);
   typedef enum logic [2:0] {IDLE, CONV, WAIT_RVS, SHIFT, DONE} state_t;

   localparam logic [31:0] CONV_LAST = 32'(CONV_CYCLES - 1);
   localparam logic [31:0] TMO_LAST  = 32'(RVS_TIMEOUT - 1);
   localparam logic [7:0]  HALF_LAST = 8'(HALF_DIV - 1);

   state_t      state_q;
   logic [31:0] cnt_q;
   logic [7:0]  half_q;
   logic [4:0]  bit_q;
   logic        cs_n_q, sclk_q, sdi_q;
   logic [30:0] tx_q, rx_q;
   logic [31:0] cmd_q;
   logic        pend_q, tx_cmd_q;
   logic [15:0] dout_q;
   logic        dout_valid_q, rvs_err_q;
   logic        rvs_m_q, rvs_s_q;

   logic        cmd_acc_d;
   logic [31:0] rx_d;
   logic [31:0] tx_word_d;

   assign cmd_acc_d = bus.cmd_valid & ~pend_q;
   assign rx_d      = {rx_q, bus.sdo};
   assign tx_word_d = pend_q ? cmd_q : 32'h0000_0000;

   assign bus.cmd_ready  = ~pend_q;
   assign bus.cs_n       = cs_n_q;
   assign bus.sclk       = sclk_q;
   assign bus.sdi        = sdi_q;
   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.rvs_err    = rvs_err_q;

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         half_q       <= '0;
         bit_q        <= '0;
         cs_n_q       <= 1'b0;
         sclk_q       <= 1'b0;
         sdi_q        <= 1'b0;
         pend_q       <= 1'b0;
         tx_cmd_q     <= 1'b0;
         dout_q       <= 16'h0000;
         dout_valid_q <= 1'b0;
         rvs_err_q    <= 1'b0;
         rvs_m_q      <= 1'b0;
         rvs_s_q      <= 1'b0;
      end else begin
         dout_valid_q <= 1'b0;
         rvs_m_q      <= bus.rvs;
         rvs_s_q      <= rvs_m_q;
         if (cmd_acc_d) begin
            pend_q <= 1'b1;
            cmd_q  <= bus.cmd_word;
         end
         case (state_q)
            IDLE: begin
               cs_n_q <= 1'b0;
               sclk_q <= 1'b0;
               sdi_q  <= 1'b0;
               if (bus.start) begin
                  state_q   <= CONV;
                  cs_n_q    <= 1'b1;
                  cnt_q     <= CONV_LAST;
                  rvs_err_q <= 1'b0;
               end
            end
            CONV: begin
               if (cnt_q == '0) begin
                  state_q <= WAIT_RVS;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q - 32'd1;
               end
            end
            WAIT_RVS: begin
               // The frame payload is frozen here; a command accepted later waits for the next frame.
               if (rvs_s_q) begin
                  state_q  <= SHIFT;
                  cs_n_q   <= 1'b0;
                  sclk_q   <= 1'b0;
                  half_q   <= HALF_LAST;
                  bit_q    <= '0;
                  tx_q     <= tx_word_d[30:0];
                  sdi_q    <= tx_word_d[31];
                  tx_cmd_q <= pend_q;
               end else if (cnt_q == TMO_LAST) begin
                  state_q   <= IDLE;
                  cs_n_q    <= 1'b0;
                  rvs_err_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
            SHIFT: begin
               if (half_q != '0) begin
                  half_q <= half_q - 8'd1;
               end else begin
                  half_q <= HALF_LAST;
                  if (!sclk_q) begin
                     sclk_q <= 1'b1;
                  end else begin
                     // Last cycle of the high phase: capture sdo, then drop sclk and advance sdi.
                     sclk_q <= 1'b0;
                     rx_q   <= rx_d[30:0];
                     if (bit_q == 5'd31) begin
                        state_q      <= DONE;
                        sdi_q        <= 1'b0;
                        dout_q       <= rx_d[31:16];
                        dout_valid_q <= 1'b1;
                        if (tx_cmd_q) pend_q <= 1'b0;
                     end else begin
                        bit_q <= bit_q + 5'd1;
                        tx_q  <= {tx_q[29:0], 1'b0};
                        sdi_q <= tx_q[30];
                     end
                  end
               end
            end
            DONE: begin
               sclk_q <= 1'b0;
               if (bus.cont) begin
                  state_q <= CONV;
                  cs_n_q  <= 1'b1;
                  cnt_q   <= CONV_LAST;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ads8681_seq.sv
// Self-checking bench for ads8681_seq with a behavioural ADC model and expected-result queues.
module tb_ads8681_seq;
   localparam int HALF_DIV    = 2;
   localparam int CONV_CYCLES = 100;
   localparam int RVS_TIMEOUT = 1000;
   localparam int FRAME_LEN   = CONV_CYCLES + 1 + 64 * HALF_DIV + 1;

   logic clk_in = 1'b0;
   logic rst_n  = 1'b0;
   always #5 clk_in = ~clk_in;

   ads8681_seq_if bus ();

   ads8681_seq #(.HALF_DIV(HALF_DIV), .CONV_CYCLES(CONV_CYCLES), .RVS_TIMEOUT(RVS_TIMEOUT)) dut (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] adc_q[$];
   logic [15:0] exp_dout_q[$];
   logic [31:0] exp_tx_q[$];

   // ADC model: MSB ready when cs_n falls, next bit on each sclk falling edge.
   logic [31:0] adc_sr  = 32'h0;
   logic        cs_last = 1'b1;
   always @(bus.cs_n or negedge bus.sclk) begin
      if (bus.cs_n !== cs_last) begin
         cs_last = bus.cs_n;
         if (bus.cs_n === 1'b0) adc_sr = (adc_q.size() > 0) ? {adc_q.pop_front(), 16'h0} : 32'h0;
      end else if (bus.cs_n === 1'b0) begin
         adc_sr = {adc_sr[30:0], 1'b0};
      end
      bus.sdo = adc_sr[31];
   end

   // Frame monitor, sampled on the falling clock edge.
   logic [31:0] sdi_sr = 32'h0;
   int pulse_cnt = 0, hi_run = 0, hi_min = 1000, hi_max = 0;
   int cs_run = 0, cs_len = 0, vld_cnt = 0, ncyc = 0;
   logic cs_prev = 1'b0, sclk_prev = 1'b0;
   always @(negedge clk_in) begin
      ncyc++;
      if (bus.cs_n === 1'b0 && cs_prev === 1'b1) begin
         pulse_cnt = 0; sdi_sr = 32'h0; hi_min = 1000; hi_max = 0;
         cs_len = cs_run; cs_run = 0;
      end
      if (bus.cs_n === 1'b1) cs_run++;
      if (bus.sclk === 1'b1 && sclk_prev === 1'b0) begin
         pulse_cnt++;
         sdi_sr = {sdi_sr[30:0], bus.sdi};
      end
      if (bus.sclk === 1'b1) hi_run++;
      else if (hi_run > 0) begin
         if (hi_run < hi_min) hi_min = hi_run;
         if (hi_run > hi_max) hi_max = hi_run;
         hi_run = 0;
      end
      if (bus.dout_valid === 1'b1) vld_cnt++;
      cs_prev = bus.cs_n; sclk_prev = bus.sclk;
   end

   task automatic tick();
      @(negedge clk_in);
      #1;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (bus.dout_valid === 1'b1) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if ({bus.cs_n, bus.sclk, bus.sdi, bus.dout_valid, bus.busy, bus.rvs_err, bus.cmd_ready} !== 7'b0000001) begin
         n_bad++;
         $display("FAIL reset_ctrl got %b want 0000001", {bus.cs_n, bus.sclk, bus.sdi, bus.dout_valid, bus.busy, bus.rvs_err, bus.cmd_ready});
      end
      n_cmp++;
      if (bus.dout !== 16'h0000) begin n_bad++; $display("FAIL reset_dout got %h want 0000", bus.dout); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      bit ok; logic [15:0] ed; logic [31:0] et; int v0;
      v0 = vld_cnt;
      adc_q.push_back(16'hA5C3); exp_dout_q.push_back(16'hA5C3); exp_tx_q.push_back(32'h0);
      pulse_start();
      n_cmp++;
      if ({bus.busy, bus.cs_n} !== 2'b11) begin n_bad++; $display("FAIL single_conv_start got %b want 11", {bus.busy, bus.cs_n}); end
      wait_valid(ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL single_timeout got no dout_valid want pulse"); end
      ed = exp_dout_q.pop_front(); et = exp_tx_q.pop_front();
      n_cmp++;
      if (bus.dout !== ed) begin n_bad++; $display("FAIL single_dout got %h want %h", bus.dout, ed); end
      n_cmp++;
      if (sdi_sr !== et) begin n_bad++; $display("FAIL single_tx got %h want %h", sdi_sr, et); end
      n_cmp++;
      if (pulse_cnt !== 32) begin n_bad++; $display("FAIL single_pulses got %0d want 32", pulse_cnt); end
      n_cmp++;
      if (hi_min !== HALF_DIV || hi_max !== HALF_DIV) begin
         n_bad++; $display("FAIL single_sclk_high got %0d..%0d want %0d", hi_min, hi_max, HALF_DIV);
      end
      // Conversion time plus the single WAIT_RVS cycle with rvs already synchronised high.
      n_cmp++;
      if (cs_len !== CONV_CYCLES + 1) begin n_bad++; $display("FAIL single_cs_high got %0d want %0d", cs_len, CONV_CYCLES + 1); end
      repeat (5) tick();
      n_cmp++;
      if (vld_cnt - v0 !== 1) begin n_bad++; $display("FAIL single_vld_count got %0d want 1", vld_cnt - v0); end
   endtask

   task automatic test_cmd();
      bit ok; logic [31:0] et;
      bus.cmd_valid = 1'b1; bus.cmd_word = 32'hD014_0003;
      tick();
      bus.cmd_valid = 1'b0; bus.cmd_word = 32'h0;
      n_cmp++;
      if (bus.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL cmd_pending got %b want 0", bus.cmd_ready); end
      for (int f = 0; f < 2; f++) begin
         adc_q.push_back(16'h1234); exp_dout_q.push_back(16'h1234);
         exp_tx_q.push_back(f == 0 ? 32'hD014_0003 : 32'h0);
         pulse_start();
         wait_valid(ok);
         n_cmp++;
         if (!ok) begin n_bad++; $display("FAIL cmd_timeout frame %0d got no dout_valid want pulse", f); end
         et = exp_tx_q.pop_front();
         n_cmp++;
         if (sdi_sr !== et) begin n_bad++; $display("FAIL cmd_tx frame %0d got %h want %h", f, sdi_sr, et); end
         n_cmp++;
         if (bus.dout !== exp_dout_q[0]) begin n_bad++; $display("FAIL cmd_dout got %h want %h", bus.dout, exp_dout_q[0]); end
         void'(exp_dout_q.pop_front());
         tick();
         n_cmp++;
         if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL cmd_ready_after got %b want 1", bus.cmd_ready); end
      end
   endtask

   task automatic test_cont();
      bit ok; logic [15:0] ed; int c_prev, v0;
      logic [15:0] vals [3] = '{16'h0001, 16'h7FFF, 16'h8000};
      v0 = vld_cnt; c_prev = 0;
      for (int f = 0; f < 3; f++) begin
         adc_q.push_back(vals[f]); exp_dout_q.push_back(vals[f]); exp_tx_q.push_back(32'h0);
      end
      bus.cont = 1'b1;
      pulse_start();
      for (int f = 0; f < 3; f++) begin
         wait_valid(ok);
         n_cmp++;
         if (!ok) begin n_bad++; $display("FAIL cont_timeout frame %0d got no dout_valid want pulse", f); end
         ed = exp_dout_q.pop_front();
         n_cmp++;
         if (bus.dout !== ed) begin n_bad++; $display("FAIL cont_dout frame %0d got %h want %h", f, bus.dout, ed); end
         n_cmp++;
         if (sdi_sr !== exp_tx_q[0]) begin n_bad++; $display("FAIL cont_tx got %h want %h", sdi_sr, exp_tx_q[0]); end
         void'(exp_tx_q.pop_front());
         if (f > 0) begin
            n_cmp++;
            if (ncyc - c_prev !== FRAME_LEN) begin n_bad++; $display("FAIL cont_period got %0d want %0d", ncyc - c_prev, FRAME_LEN); end
         end
         c_prev = ncyc;
         tick();
         n_cmp++;
         if (f < 2 && bus.cs_n !== 1'b1) begin n_bad++; $display("FAIL cont_cs_rise frame %0d got %b want 1", f, bus.cs_n); end
         else if (f == 2 && {bus.cs_n, bus.busy} !== 2'b00) begin n_bad++; $display("FAIL cont_stop got %b want 00", {bus.cs_n, bus.busy}); end
         if (f == 1) bus.cont = 1'b0;
      end
      n_cmp++;
      if (vld_cnt - v0 !== 3) begin n_bad++; $display("FAIL cont_vld_count got %0d want 3", vld_cnt - v0); end
   endtask

   task automatic test_timeout();
      bit ok; int k, v0;
      bus.rvs = 1'b0;
      repeat (3) tick();
      bus.cmd_valid = 1'b1; bus.cmd_word = 32'h1234_5678;
      tick();
      bus.cmd_valid = 1'b0;
      v0 = vld_cnt;
      pulse_start();
      k = 1;
      while (bus.rvs_err !== 1'b1 && k < 1500) begin tick(); k++; end
      n_cmp++;
      if (k !== CONV_CYCLES + RVS_TIMEOUT + 1) begin n_bad++; $display("FAIL tmo_latency got %0d want %0d", k, CONV_CYCLES + RVS_TIMEOUT + 1); end
      n_cmp++;
      if ({bus.rvs_err, bus.busy, bus.cs_n, bus.cmd_ready} !== 4'b1000) begin
         n_bad++; $display("FAIL tmo_state got %b want 1000", {bus.rvs_err, bus.busy, bus.cs_n, bus.cmd_ready});
      end
      n_cmp++;
      if (vld_cnt !== v0) begin n_bad++; $display("FAIL tmo_no_valid got %0d want %0d", vld_cnt, v0); end
      bus.rvs = 1'b1;
      adc_q.push_back(16'h3C3C); exp_dout_q.push_back(16'h3C3C); exp_tx_q.push_back(32'h1234_5678);
      pulse_start();
      n_cmp++;
      if (bus.rvs_err !== 1'b0) begin n_bad++; $display("FAIL tmo_err_clear got %b want 0", bus.rvs_err); end
      wait_valid(ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL tmo_retry_timeout got no dout_valid want pulse"); end
      n_cmp++;
      if (sdi_sr !== exp_tx_q[0]) begin n_bad++; $display("FAIL tmo_retained_cmd got %h want %h", sdi_sr, exp_tx_q[0]); end
      void'(exp_tx_q.pop_front());
      n_cmp++;
      if (bus.dout !== exp_dout_q[0]) begin n_bad++; $display("FAIL tmo_retry_dout got %h want %h", bus.dout, exp_dout_q[0]); end
      void'(exp_dout_q.pop_front());
      tick();
   endtask

   task automatic test_back_to_back();
      bit ok; logic [31:0] et;
      bus.cmd_valid = 1'b1; bus.cmd_word = 32'hCAFE_0001;
      tick();
      bus.cmd_word = 32'hBEEF_0002;
      n_cmp++;
      if (bus.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready got %b want 0", bus.cmd_ready); end
      tick();
      bus.cmd_valid = 1'b0;
      for (int f = 0; f < 2; f++) begin
         adc_q.push_back(16'h5555); exp_dout_q.push_back(16'h5555);
         exp_tx_q.push_back(f == 0 ? 32'hCAFE_0001 : 32'h0);
         pulse_start();
         wait_valid(ok);
         n_cmp++;
         if (!ok) begin n_bad++; $display("FAIL b2b_timeout frame %0d got no dout_valid want pulse", f); end
         et = exp_tx_q.pop_front();
         n_cmp++;
         if (sdi_sr !== et) begin n_bad++; $display("FAIL b2b_tx frame %0d got %h want %h", f, sdi_sr, et); end
         n_cmp++;
         if (bus.dout !== exp_dout_q[0]) begin n_bad++; $display("FAIL b2b_dout got %h want %h", bus.dout, exp_dout_q[0]); end
         void'(exp_dout_q.pop_front());
         tick();
      end
   endtask

   task automatic test_reset_mid();
      int k, v0;
      adc_q.push_back(16'h0F0F);
      v0 = vld_cnt;
      pulse_start();
      k = 0;
      while (pulse_cnt !== 10 && k < 1000) begin tick(); k++; end
      n_cmp++;
      if (pulse_cnt !== 10) begin n_bad++; $display("FAIL rstmid_reach got %0d want 10", pulse_cnt); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n_cmp++;
      if ({bus.cs_n, bus.sclk, bus.busy, bus.dout_valid} !== 4'b0000) begin
         n_bad++; $display("FAIL rstmid_ctrl got %b want 0000", {bus.cs_n, bus.sclk, bus.busy, bus.dout_valid});
      end
      n_cmp++;
      if (bus.dout !== 16'h0000) begin n_bad++; $display("FAIL rstmid_dout got %h want 0000", bus.dout); end
      repeat (200) tick();
      n_cmp++;
      if (vld_cnt !== v0 || bus.busy !== 1'b0) begin
         n_bad++; $display("FAIL rstmid_no_valid got %0d/%b want %0d/0", vld_cnt, bus.busy, v0);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.start = 1'b0; bus.cont = 1'b0; bus.cmd_valid = 1'b0;
      bus.cmd_word = 32'h0; bus.rvs = 1'b1;
      test_reset();
      test_single();
      test_cmd();
      test_cont();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
